// File: rtl/dma_xfer_splitter.sv
// Purpose : split one (src, dst, len) DMA command into sub-commands that never exceed
//           MAX_CHUNK_BYTES and never cross a BOUNDARY_BYTES line on the host-side address.
// Latency : new_cmd -> busy next cycle, first sub_valid one cycle later; one bubble between
//           sub-commands; last handshake -> done_pulse next cycle -> idle the cycle after.
// Backpressure: sub_* are held stable while sub_valid is high and sub_ready is low; commands
//           arriving while busy are dropped and flagged through err_overrun.
//
// Ports:
//   clk, reset, sclr          clock, synchronous active-high reset and software clear
//   new_cmd, cmd_src/dst/len  one-cycle command strobe with its start addresses and length
//   busy                      command in progress (CALC/ISSUE/DONE)
//   sub_valid/sub_ready       sub-command handshake; sub_src/dst/len/last carry the payload
//   done_pulse                one-cycle completion strobe
//   chunk_count               sub-commands accepted since reset/sclr (wraps)
//   err_unaligned, err_overrun sticky error flags

module dma_xfer_splitter #(
    parameter int    SRC_ADDR_WIDTH    = 48,
    parameter int    DST_ADDR_WIDTH    = 48,
    parameter int    XFER_LENGTH_WIDTH = 40,
    parameter int    BYTE_WIDTH        = 6,
    parameter int    MAX_CHUNK_BYTES   = 4096,
    parameter int    BOUNDARY_BYTES    = 4096,
    parameter string DMA_DIR           = "H2F"
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sclr,
    input  logic                         new_cmd,
    input  logic [SRC_ADDR_WIDTH-1:0]    cmd_src,
    input  logic [DST_ADDR_WIDTH-1:0]    cmd_dst,
    input  logic [XFER_LENGTH_WIDTH-1:0] cmd_len,
    output logic                         busy,
    output logic                         sub_valid,
    input  logic                         sub_ready,
    output logic [SRC_ADDR_WIDTH-1:0]    sub_src,
    output logic [DST_ADDR_WIDTH-1:0]    sub_dst,
    output logic [XFER_LENGTH_WIDTH-1:0] sub_len,
    output logic                         sub_last,
    output logic                         done_pulse,
    output logic [31:0]                  chunk_count,
    output logic                         err_unaligned,
    output logic                         err_overrun
);

    localparam int BND_LOG = $clog2(BOUNDARY_BYTES);
    // The host side of the transfer is the one whose address must respect page lines.
    localparam bit HOST_IS_DST = (DMA_DIR == "F2H");
    localparam logic [XFER_LENGTH_WIDTH-1:0] MAX_LEN = XFER_LENGTH_WIDTH'(MAX_CHUNK_BYTES);
    localparam logic [XFER_LENGTH_WIDTH-1:0] BND_LEN = XFER_LENGTH_WIDTH'(BOUNDARY_BYTES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working registers: next sub-command start addresses and bytes still to issue.
    logic [SRC_ADDR_WIDTH-1:0]    src_r;
    logic [DST_ADDR_WIDTH-1:0]    dst_r;
    logic [XFER_LENGTH_WIDTH-1:0] rem_r;

    logic [BND_LOG-1:0]           host_off;
    logic [XFER_LENGTH_WIDTH-1:0] room;
    logic [XFER_LENGTH_WIDTH-1:0] chunk;
    logic [XFER_LENGTH_WIDTH-1:0] rem_after;
    logic                         cmd_unaligned;
    logic                         handshake;

    assign busy       = (state != S_IDLE);
    assign sub_valid  = (state == S_ISSUE);
    assign done_pulse = (state == S_DONE);
    assign handshake  = sub_valid && sub_ready;

    assign cmd_unaligned = (|cmd_src[BYTE_WIDTH-1:0]) ||
                           (|cmd_dst[BYTE_WIDTH-1:0]) ||
                           (|cmd_len[BYTE_WIDTH-1:0]);

    // Only the offset within the current page matters for the boundary limit.
    assign host_off = HOST_IS_DST ? dst_r[BND_LOG-1:0] : src_r[BND_LOG-1:0];
    assign room     = BND_LEN - XFER_LENGTH_WIDTH'(host_off);

    // chunk = min(remaining, MAX_CHUNK_BYTES, bytes left in the host page)
    always_comb begin
        chunk = rem_r;
        if (chunk > MAX_LEN) begin
            chunk = MAX_LEN;
        end
        if (chunk > room) begin
            chunk = room;
        end
    end

    // sub_len never exceeds rem_r, so this cannot underflow.
    assign rem_after = rem_r - sub_len;

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (new_cmd) begin
                    if (cmd_len == '0) begin
                        state_nxt = S_DONE;
                    end else if (cmd_unaligned) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_CALC;
                    end
                end
            end
            S_CALC: begin
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (handshake) begin
                    state_nxt = (rem_after == '0) ? S_DONE : S_CALC;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State register and datapath. sclr behaves exactly like reset and also wins over new_cmd.
    always_ff @(posedge clk) begin
        if (reset || sclr) begin
            state         <= S_IDLE;
            src_r         <= '0;
            dst_r         <= '0;
            rem_r         <= '0;
            sub_src       <= '0;
            sub_dst       <= '0;
            sub_len       <= '0;
            sub_last      <= 1'b0;
            chunk_count   <= '0;
            err_unaligned <= 1'b0;
            err_overrun   <= 1'b0;
        end else begin
            state <= state_nxt;

            case (state)
                S_IDLE: begin
                    if (new_cmd) begin
                        src_r <= cmd_src;
                        dst_r <= cmd_dst;
                        rem_r <= cmd_len;
                        // A zero-length command completes without touching the flags.
                        if ((cmd_len != '0) && cmd_unaligned) begin
                            err_unaligned <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    sub_src  <= src_r;
                    sub_dst  <= dst_r;
                    sub_len  <= chunk;
                    sub_last <= (chunk == rem_r);
                end
                S_ISSUE: begin
                    if (handshake) begin
                        src_r       <= src_r + SRC_ADDR_WIDTH'(sub_len);
                        dst_r       <= dst_r + DST_ADDR_WIDTH'(sub_len);
                        rem_r       <= rem_after;
                        chunk_count <= chunk_count + 32'd1;
                    end
                end
                default: begin
                end
            endcase

            if (new_cmd && (state != S_IDLE)) begin
                err_overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_xfer_splitter.sv
// Purpose : self-checking bench for dma_xfer_splitter (H2F and F2H instances side by side).
// Latency : inputs driven 1ns after the rising edge, outputs sampled 1ns after or on the falling edge.
// Backpressure: sub_ready is driven by the scenarios to exercise stalls.

module tb_dma_xfer_splitter;

    typedef struct packed {
        logic [47:0] src;
        logic [47:0] dst;
        logic [39:0] len;
        logic        last;
    } sub_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sclr = 1'b0;
    logic        new_cmd = 1'b0;
    logic        new_cmd_f = 1'b0;
    logic [47:0] cmd_src = '0;
    logic [47:0] cmd_dst = '0;
    logic [39:0] cmd_len = '0;
    logic        sub_ready = 1'b0;

    logic        busy, sub_valid, sub_last, done_pulse, err_unaligned, err_overrun;
    logic [47:0] sub_src, sub_dst;
    logic [39:0] sub_len;
    logic [31:0] chunk_count;

    logic        busy_f, sub_valid_f, sub_last_f, done_pulse_f, err_unaligned_f, err_overrun_f;
    logic [47:0] sub_src_f, sub_dst_f;
    logic [39:0] sub_len_f;
    logic [31:0] chunk_count_f;

    int   vectors = 0;
    int   miscompares = 0;
    int   done_cnt = 0;
    int   done_cnt_f = 0;
    int   exp_chunks = 0;
    int   exp_chunks_f = 0;
    sub_t exp_q[$];
    sub_t exp_qf[$];

    always #5 clk = ~clk;

    dma_xfer_splitter #(.DMA_DIR("H2F")) dut (
        .clk(clk), .reset(reset), .sclr(sclr), .new_cmd(new_cmd),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy), .sub_valid(sub_valid), .sub_ready(sub_ready),
        .sub_src(sub_src), .sub_dst(sub_dst), .sub_len(sub_len), .sub_last(sub_last),
        .done_pulse(done_pulse), .chunk_count(chunk_count),
        .err_unaligned(err_unaligned), .err_overrun(err_overrun)
    );

    dma_xfer_splitter #(.DMA_DIR("F2H")) dut_f (
        .clk(clk), .reset(reset), .sclr(sclr), .new_cmd(new_cmd_f),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len),
        .busy(busy_f), .sub_valid(sub_valid_f), .sub_ready(sub_ready),
        .sub_src(sub_src_f), .sub_dst(sub_dst_f), .sub_len(sub_len_f), .sub_last(sub_last_f),
        .done_pulse(done_pulse_f), .chunk_count(chunk_count_f),
        .err_unaligned(err_unaligned_f), .err_overrun(err_overrun_f)
    );

    // Scoreboard: every accepted sub-command is popped against the expected queue.
    always @(negedge clk) begin
        if (!reset && !sclr) begin
            if (sub_valid && sub_ready) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL h2f_sub unexpected: got src=%h dst=%h len=%h last=%b, required none",
                             sub_src, sub_dst, sub_len, sub_last);
                end else begin
                    sub_t e;
                    e = exp_q.pop_front();
                    if ({sub_src, sub_dst, sub_len, sub_last} !== e) begin
                        miscompares++;
                        $display("FAIL h2f_sub: got src=%h dst=%h len=%h last=%b, required src=%h dst=%h len=%h last=%b",
                                 sub_src, sub_dst, sub_len, sub_last, e.src, e.dst, e.len, e.last);
                    end
                end
            end
            if (sub_valid_f && sub_ready) begin
                vectors++;
                if (exp_qf.size() == 0) begin
                    miscompares++;
                    $display("FAIL f2h_sub unexpected: got src=%h dst=%h len=%h last=%b, required none",
                             sub_src_f, sub_dst_f, sub_len_f, sub_last_f);
                end else begin
                    sub_t e;
                    e = exp_qf.pop_front();
                    if ({sub_src_f, sub_dst_f, sub_len_f, sub_last_f} !== e) begin
                        miscompares++;
                        $display("FAIL f2h_sub: got src=%h dst=%h len=%h last=%b, required src=%h dst=%h len=%h last=%b",
                                 sub_src_f, sub_dst_f, sub_len_f, sub_last_f, e.src, e.dst, e.len, e.last);
                    end
                end
            end
            if (done_pulse)   done_cnt++;
            if (done_pulse_f) done_cnt_f++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit f, input logic [47:0] s, input logic [47:0] d,
                        input logic [39:0] l, input bit last);
        sub_t e;
        e = '{src: s, dst: d, len: l, last: last};
        if (f) begin
            exp_qf.push_back(e);
            exp_chunks_f++;
        end else begin
            exp_q.push_back(e);
            exp_chunks++;
        end
    endtask

    // Reference split: walk the command, cutting at 4 KiB size and at 4 KiB host pages.
    task automatic model_push(input bit f, input logic [47:0] s0, input logic [47:0] d0,
                              input logic [39:0] len);
        logic [47:0] s, d, host;
        logic [39:0] rem, c, room;
        s = s0; d = d0; rem = len;
        while (rem != 0) begin
            host = f ? d : s;
            room = 40'd4096 - 40'(host % 48'd4096);
            c = (rem < 40'd4096) ? rem : 40'd4096;
            if (c > room) c = room;
            push(f, s, d, c, c == rem);
            s = s + 48'(c);
            d = d + 48'(c);
            rem = rem - c;
        end
    endtask

    task automatic send_cmd(input bit f, input logic [47:0] s, input logic [47:0] d,
                            input logic [39:0] l);
        cmd_src = s; cmd_dst = d; cmd_len = l;
        if (f) new_cmd_f = 1'b1; else new_cmd = 1'b1;
        tick();
        new_cmd = 1'b0;
        new_cmd_f = 1'b0;
    endtask

    task automatic wait_done(input bit f, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (f ? done_pulse_f : done_pulse) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({busy, sub_valid, done_pulse, sub_last, err_unaligned, err_overrun} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 000000",
                     {busy, sub_valid, done_pulse, sub_last, err_unaligned, err_overrun});
        end
        vectors++;
        if ({sub_src, sub_dst, sub_len, chunk_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got src=%h dst=%h len=%h cnt=%h, required all 0",
                     sub_src, sub_dst, sub_len, chunk_count);
        end
        vectors++;
        if ({busy_f, sub_valid_f, done_pulse_f, chunk_count_f} !== '0) begin
            miscompares++;
            $display("FAIL reset_f2h: got busy=%b valid=%b done=%b cnt=%h, required 0",
                     busy_f, sub_valid_f, done_pulse_f, chunk_count_f);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_h2f_split();
        bit ok;
        int d0;
        d0 = done_cnt;
        sub_ready = 1'b1;
        push(0, 48'h0,    48'h8000, 40'h1000, 1'b0);
        push(0, 48'h1000, 48'h9000, 40'h1000, 1'b0);
        push(0, 48'h2000, 48'hA000, 40'h1000, 1'b1);
        send_cmd(0, 48'h0, 48'h8000, 40'h3000);
        vectors++;
        if ({busy, sub_valid} !== 2'b10) begin
            miscompares++;
            $display("FAIL h2f_latency_t1: got busy,valid=%b, required 10", {busy, sub_valid});
        end
        tick();
        vectors++;
        if (sub_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL h2f_latency_t2: got sub_valid=%b, required 1", sub_valid);
        end
        wait_done(0, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL h2f_done_timeout: got no done_pulse, required one");
        end
        vectors++;
        if (chunk_count !== 32'(exp_chunks)) begin
            miscompares++;
            $display("FAIL h2f_chunk_count: got %0d, required %0d", chunk_count, exp_chunks);
        end
        tick();
        vectors++;
        if ({busy, done_pulse} !== 2'b00) begin
            miscompares++;
            $display("FAIL h2f_idle_after_done: got busy,done=%b, required 00", {busy, done_pulse});
        end
        vectors++;
        if (done_cnt - d0 != 1 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL h2f_done_once: got done=%0d left=%0d, required done=1 left=0",
                     done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_boundary_split();
        bit ok;
        push(0, 48'hF80,  48'h10000, 40'h80,  1'b0);
        push(0, 48'h1000, 48'h10080, 40'h180, 1'b1);
        send_cmd(0, 48'hF80, 48'h10000, 40'h200);
        wait_done(0, ok);
        vectors++;
        if (!ok || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL boundary_done: got ok=%b left=%0d, required ok=1 left=0", ok, exp_q.size());
        end
        vectors++;
        if (chunk_count !== 32'(exp_chunks)) begin
            miscompares++;
            $display("FAIL boundary_chunk_count: got %0d, required %0d", chunk_count, exp_chunks);
        end
        tick();
    endtask

    task automatic test_f2h_split();
        bit ok;
        push(1, 48'h0,  48'h1FC0, 40'h40, 1'b0);
        push(1, 48'h40, 48'h2000, 40'h40, 1'b1);
        send_cmd(1, 48'h0, 48'h1FC0, 40'h80);
        wait_done(1, ok);
        vectors++;
        if (!ok || exp_qf.size() != 0) begin
            miscompares++;
            $display("FAIL f2h_done: got ok=%b left=%0d, required ok=1 left=0", ok, exp_qf.size());
        end
        vectors++;
        if (chunk_count_f !== 32'(exp_chunks_f)) begin
            miscompares++;
            $display("FAIL f2h_chunk_count: got %0d, required %0d", chunk_count_f, exp_chunks_f);
        end
        tick();
    endtask

    task automatic test_stall_overrun();
        bit ok;
        sub_ready = 1'b0;
        push(0, 48'h2000, 48'h3000, 40'h1000, 1'b0);
        push(0, 48'h3000, 48'h4000, 40'h1000, 1'b1);
        send_cmd(0, 48'h2000, 48'h3000, 40'h2000);
        tick();
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({sub_valid, sub_src, sub_dst, sub_len, sub_last} !==
                {1'b1, 48'h2000, 48'h3000, 40'h1000, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got valid=%b src=%h dst=%h len=%h last=%b, required 1 2000 3000 1000 0",
                         i, sub_valid, sub_src, sub_dst, sub_len, sub_last);
            end
            if (i == 1) begin
                cmd_src = 48'h40000; cmd_dst = 48'h50000; cmd_len = 40'h40;
                new_cmd = 1'b1;
            end else begin
                new_cmd = 1'b0;
            end
            tick();
        end
        new_cmd = 1'b0;
        vectors++;
        if ({err_overrun, err_unaligned, busy} !== 3'b101) begin
            miscompares++;
            $display("FAIL overrun_flag: got ovr,unal,busy=%b, required 101",
                     {err_overrun, err_unaligned, busy});
        end
        sub_ready = 1'b1;
        wait_done(0, ok);
        vectors++;
        if (!ok || chunk_count !== 32'(exp_chunks) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL stall_complete: got ok=%b cnt=%0d left=%0d, required ok=1 cnt=%0d left=0",
                     ok, chunk_count, exp_q.size(), exp_chunks);
        end
        repeat (4) tick();
        vectors++;
        if ({busy, sub_valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL overrun_cmd_ignored: got busy,valid=%b, required 00", {busy, sub_valid});
        end
    endtask

    task automatic test_zero_unaligned();
        int  d0;
        bit  saw_valid, saw_done;
        d0 = done_cnt;
        sub_ready = 1'b1;
        send_cmd(0, 48'h0, 48'h0, 40'h0);
        vectors++;
        if ({busy, done_pulse, sub_valid} !== 3'b110) begin
            miscompares++;
            $display("FAIL zero_len_t1: got busy,done,valid=%b, required 110", {busy, done_pulse, sub_valid});
        end
        tick();
        vectors++;
        if ({busy, done_pulse, done_cnt - d0 == 1} !== 3'b001) begin
            miscompares++;
            $display("FAIL zero_len_t2: got busy=%b done=%b pulses=%0d, required 0 0 1",
                     busy, done_pulse, done_cnt - d0);
        end
        send_cmd(0, 48'h20, 48'h100, 40'h100);
        vectors++;
        if ({err_unaligned, busy} !== 2'b10) begin
            miscompares++;
            $display("FAIL unaligned_flag: got unal,busy=%b, required 10", {err_unaligned, busy});
        end
        saw_valid = 1'b0;
        saw_done = done_pulse;
        for (int i = 0; i < 4; i++) begin
            tick();
            saw_valid |= sub_valid;
            saw_done |= done_pulse;
        end
        vectors++;
        if ({saw_valid, saw_done, chunk_count == 32'(exp_chunks)} !== 3'b001) begin
            miscompares++;
            $display("FAIL unaligned_no_activity: got valid=%b done=%b cnt=%0d, required 0 0 %0d",
                     saw_valid, saw_done, chunk_count, exp_chunks);
        end
    endtask

    task automatic test_sclr_abort();
        bit ok;
        sub_ready = 1'b0;
        push(0, 48'h10000, 48'h20000, 40'h1000, 1'b0);
        send_cmd(0, 48'h10000, 48'h20000, 40'h3000);
        for (int i = 0; i < 10 && !sub_valid; i++) tick();
        sub_ready = 1'b1;
        tick();
        sub_ready = 1'b0;
        for (int i = 0; i < 10 && !sub_valid; i++) tick();
        vectors++;
        if ({sub_valid, sub_src, sub_dst} !== {1'b1, 48'h11000, 48'h21000}) begin
            miscompares++;
            $display("FAIL sclr_second_sub: got valid=%b src=%h dst=%h, required 1 11000 21000",
                     sub_valid, sub_src, sub_dst);
        end
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        exp_chunks = 0;
        exp_chunks_f = 0;
        vectors++;
        if ({sub_valid, busy, done_pulse, err_unaligned, err_overrun} !== 5'b0 ||
            chunk_count !== 32'd0 || chunk_count_f !== 32'd0) begin
            miscompares++;
            $display("FAIL sclr_clear: got valid=%b busy=%b done=%b unal=%b ovr=%b cnt=%0d cnt_f=%0d, required all 0",
                     sub_valid, busy, done_pulse, err_unaligned, err_overrun, chunk_count, chunk_count_f);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sclr_first_sub_seen: got %0d pending, required 0", exp_q.size());
        end
        sub_ready = 1'b1;
        push(0, 48'h0,    48'h5000, 40'h1000, 1'b0);
        push(0, 48'h1000, 48'h6000, 40'h40,   1'b1);
        send_cmd(0, 48'h0, 48'h5000, 40'h1040);
        wait_done(0, ok);
        vectors++;
        if (!ok || chunk_count !== 32'd2 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL sclr_fresh_cmd: got ok=%b cnt=%0d left=%0d, required ok=1 cnt=2 left=0",
                     ok, chunk_count, exp_q.size());
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit          ok;
        logic [47:0] s, d;
        logic [39:0] l;
        sub_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            if (k == 0) begin
                s = 48'hFFFF_FFFF_F000; d = 48'h0; l = 40'h2000;  // address wraps to 0
            end else begin
                s = 48'($urandom) << 6;
                d = 48'($urandom) << 6;
                l = 40'($urandom_range(1, 160)) << 6;
            end
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL b2b_ready[%0d]: got busy=%b, required 0", k, busy);
            end
            model_push(0, s, d, l);
            send_cmd(0, s, d, l);
            wait_done(0, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL b2b_done[%0d]: got no done_pulse, required one", k);
            end
            tick();
        end
        vectors++;
        if (chunk_count !== 32'(exp_chunks) || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL b2b_totals: got cnt=%0d left=%0d, required cnt=%0d left=0",
                     chunk_count, exp_q.size(), exp_chunks);
        end
    endtask

    initial begin
        test_reset();
        test_h2f_split();
        test_boundary_split();
        test_f2h_split();
        test_stall_overrun();
        test_zero_unaligned();
        test_sclr_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
